// File: rtl/rs_hs_pkg.sv
// Shared sizing helpers and constants for the relay-station handshake pipeline.
package rs_hs_pkg;

    // Smallest grace slack a conventional head/body/tail chain needs.
    localparam int unsigned RS_HS_MIN_SLACK = 4;

    // Physical entry count of a tail FIFO: visible depth plus in-flight slack.
    function automatic int unsigned calc_real_depth(input int unsigned depth,
                                                    input int unsigned grace);
        return depth + grace;
    endfunction

    // Round-trip stage count between the tail gate and the writer.
    function automatic int unsigned calc_grace(input int unsigned body_level,
                                               input int unsigned ready_in_head,
                                               input int unsigned vd_in_head,
                                               input int unsigned extra_before_tail);
        return 2 * body_level + ready_in_head + vd_in_head + 2 * extra_before_tail;
    endfunction

endpackage : rs_hs_pkg

// File: rtl/rs_hs_fifo_mem.sv
// Entry storage: one synchronous write port, one asynchronous read port.
module rs_hs_fifo_mem #(
    parameter  int unsigned DATA_WIDTH = 32,
    parameter  int unsigned DEPTH      = 28,
    parameter  string       MEM_STYLE  = "distributed",
    localparam int unsigned ADDR_WIDTH = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  we_i,
    input  logic [ADDR_WIDTH-1:0] waddr_i,
    input  logic [DATA_WIDTH-1:0] wdata_i,
    input  logic [ADDR_WIDTH-1:0] raddr_i,
    output logic [DATA_WIDTH-1:0] rdata_o
);

    if (MEM_STYLE == "block") begin : g_block
        (* ram_style = "block" *) logic [DATA_WIDTH-1:0] mem_q [DEPTH];

        // Synchronous write port.
        always_ff @(posedge clk) begin
            if (we_i) begin
                mem_q[waddr_i] <= wdata_i;
            end
        end

        assign rdata_o = mem_q[raddr_i];
    end else begin : g_dist
        (* ram_style = "distributed" *) logic [DATA_WIDTH-1:0] mem_q [DEPTH];

        // Synchronous write port.
        always_ff @(posedge clk) begin
            if (we_i) begin
                mem_q[waddr_i] <= wdata_i;
            end
        end

        assign rdata_o = mem_q[raddr_i];
    end

endmodule : rs_hs_fifo_mem

// File: rtl/rs_hs_pipeline_tail_fifo.sv
// Tail FIFO of the relay-station pipeline: early back-pressure at DEPTH,
// GRACE_PERIOD spare slots for writes already in flight, FWFT read port.
module rs_hs_pipeline_tail_fifo
    import rs_hs_pkg::*;
#(
    parameter  int unsigned DATA_WIDTH   = 32,
    parameter  int unsigned DEPTH        = 24,
    parameter  int unsigned GRACE_PERIOD = 4,
    parameter  string       MEM_STYLE    = "distributed",
    localparam int unsigned REAL_DEPTH   = calc_real_depth(DEPTH, GRACE_PERIOD),
    localparam int unsigned ADDR_WIDTH   = $clog2(REAL_DEPTH),
    localparam int unsigned CNT_WIDTH    = $clog2(REAL_DEPTH + 1)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] if_din,
    input  logic                  if_write,
    output logic                  if_full_n,
    output logic [DATA_WIDTH-1:0] if_dout,
    output logic                  if_empty_n,
    input  logic                  if_read,
    output logic [CNT_WIDTH-1:0]  occupancy,
    output logic                  overflow
);

    logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_WIDTH-1:0]  occ_q, occ_d;
    logic                  full_n_q, full_n_d;
    logic                  empty_n_q, empty_n_d;
    logic                  overflow_q, overflow_d;
    logic                  wr_en, rd_en, at_cap;

    // Pointers wrap at REAL_DEPTH, which need not be a power of two.
    function automatic logic [ADDR_WIDTH-1:0] ptr_inc(input logic [ADDR_WIDTH-1:0] p);
        return (p == ADDR_WIDTH'(REAL_DEPTH - 1)) ? '0 : p + ADDR_WIDTH'(1);
    endfunction

    // Accept decisions, next occupancy, next pointers and next flags.
    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        occ_d      = occ_q;
        overflow_d = overflow_q;

        rd_en  = if_read && empty_n_q;
        at_cap = (occ_q == CNT_WIDTH'(REAL_DEPTH));
        // A read at full frees its slot in the same cycle, so the write still fits.
        wr_en  = if_write && (!at_cap || rd_en);

        if (wr_en && !rd_en) begin
            occ_d = occ_q + CNT_WIDTH'(1);
        end else if (!wr_en && rd_en) begin
            occ_d = occ_q - CNT_WIDTH'(1);
        end

        if (wr_en) begin
            wr_ptr_d = ptr_inc(wr_ptr_q);
        end
        if (rd_en) begin
            rd_ptr_d = ptr_inc(rd_ptr_q);
        end

        if (if_write && !wr_en) begin
            overflow_d = 1'b1;
        end

        full_n_d  = (occ_d < CNT_WIDTH'(DEPTH));
        empty_n_d = (occ_d != '0);
    end

    // State register; reset drops all entries and holds back-pressure for one cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            occ_q      <= '0;
            full_n_q   <= 1'b0;
            empty_n_q  <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            occ_q      <= occ_d;
            full_n_q   <= full_n_d;
            empty_n_q  <= empty_n_d;
            overflow_q <= overflow_d;
        end
    end

    rs_hs_fifo_mem #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (REAL_DEPTH),
        .MEM_STYLE  (MEM_STYLE)
    ) u_mem (
        .clk     (clk),
        .we_i    (wr_en && !reset),
        .waddr_i (wr_ptr_q),
        .wdata_i (if_din),
        .raddr_i (rd_ptr_q),
        .rdata_o (if_dout)
    );

    assign if_full_n  = full_n_q;
    assign if_empty_n = empty_n_q;
    assign occupancy  = occ_q;
    assign overflow   = overflow_q;

endmodule : rs_hs_pipeline_tail_fifo

// File: tb/tb_rs_hs_pipeline_tail_fifo.sv
// Scoreboard bench for the tail FIFO with DEPTH=4, GRACE_PERIOD=2, DATA_WIDTH=8.
module tb_rs_hs_pipeline_tail_fifo;

    localparam int unsigned DW    = 8;
    localparam int unsigned DEP   = 4;
    localparam int unsigned GRACE = 2;
    localparam int unsigned RDEP  = DEP + GRACE;
    localparam int unsigned CW    = $clog2(RDEP + 1);

    logic          clk = 1'b0;
    logic          reset;
    logic [DW-1:0] if_din;
    logic          if_write;
    logic          if_read;
    logic          if_full_n;
    logic [DW-1:0] if_dout;
    logic          if_empty_n;
    logic [CW-1:0] occupancy;
    logic          overflow;

    int            checks   = 0;
    int            failures = 0;
    int            n_reads  = 0;
    logic [DW-1:0] sb [$];
    int            m_occ    = 0;
    logic [DW-1:0] mon_exp;

    always #5 clk = ~clk;

    rs_hs_pipeline_tail_fifo #(
        .DATA_WIDTH   (DW),
        .DEPTH        (DEP),
        .GRACE_PERIOD (GRACE),
        .MEM_STYLE    ("distributed")
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .if_din     (if_din),
        .if_write   (if_write),
        .if_full_n  (if_full_n),
        .if_dout    (if_dout),
        .if_empty_n (if_empty_n),
        .if_read    (if_read),
        .occupancy  (occupancy),
        .overflow   (overflow)
    );

    // Read monitor: every accepted pop must match the oldest expected word.
    always @(negedge clk) begin
        if (!reset && if_read && if_empty_n) begin
            checks++;
            n_reads++;
            if (sb.size() == 0) begin
                failures++;
                $display("FAIL rd_data: read of %h with no word expected", if_dout);
            end else begin
                mon_exp = sb.pop_front();
                if (if_dout !== mon_exp) begin
                    failures++;
                    $display("FAIL rd_data: got %h expected %h", if_dout, mon_exp);
                end
            end
        end
    end

    // Drive one cycle and push accepted writes into the scoreboard.
    task automatic step(input logic wr, input logic [DW-1:0] d, input logic rd);
        bit m_rd, m_wr;
        if_write = wr;
        if_din   = d;
        if_read  = rd;
        m_rd = rd && (m_occ > 0);
        m_wr = wr && ((m_occ < int'(RDEP)) || m_rd);
        if (m_wr) sb.push_back(d);
        m_occ = m_occ + int'(m_wr) - int'(m_rd);
        @(posedge clk);
        #1;
        if_write = 1'b0;
        if_read  = 1'b0;
    endtask

    task automatic apply_reset();
        reset    = 1'b1;
        if_write = 1'b0;
        if_read  = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b0;
        m_occ = 0;
        sb.delete();
        step(1'b0, '0, 1'b0);
    endtask

    task automatic test_reset();
        reset    = 1'b1;
        if_write = 1'b0;
        if_read  = 1'b0;
        if_din   = '0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (occupancy !== CW'(0) || if_empty_n !== 1'b0 || if_full_n !== 1'b0 || overflow !== 1'b0) begin
            failures++;
            $display("FAIL reset_state: occ=%0d empty_n=%b full_n=%b ovf=%b expected 0 0 0 0",
                     occupancy, if_empty_n, if_full_n, overflow);
        end
        reset = 1'b0;
        step(1'b0, '0, 1'b0);
        checks++;
        if (if_full_n !== 1'b1) begin
            failures++;
            $display("FAIL reset_release_full_n: got %b expected 1", if_full_n);
        end
    endtask

    task automatic test_fill();
        for (int i = 0; i < 3; i++) step(1'b1, DW'(8'h11 + i), 1'b0);
        checks++;
        if (occupancy !== CW'(3) || if_full_n !== 1'b1) begin
            failures++;
            $display("FAIL fill_3: occ=%0d full_n=%b expected 3 1", occupancy, if_full_n);
        end
        step(1'b1, 8'h14, 1'b0);
        checks++;
        if (occupancy !== CW'(4) || if_full_n !== 1'b0 || if_empty_n !== 1'b1) begin
            failures++;
            $display("FAIL fill_4: occ=%0d full_n=%b empty_n=%b expected 4 0 1",
                     occupancy, if_full_n, if_empty_n);
        end
        checks++;
        if (if_dout !== 8'h11) begin
            failures++;
            $display("FAIL fill_head: got %h expected 11", if_dout);
        end
    endtask

    task automatic test_grace();
        step(1'b1, 8'h15, 1'b0);
        step(1'b1, 8'h16, 1'b0);
        checks++;
        if (occupancy !== CW'(6) || overflow !== 1'b0 || if_full_n !== 1'b0) begin
            failures++;
            $display("FAIL grace_absorb: occ=%0d ovf=%b full_n=%b expected 6 0 0",
                     occupancy, overflow, if_full_n);
        end
        step(1'b1, 8'h17, 1'b0);
        checks++;
        if (occupancy !== CW'(6) || overflow !== 1'b1) begin
            failures++;
            $display("FAIL grace_drop: occ=%0d ovf=%b expected 6 1", occupancy, overflow);
        end
        for (int i = 0; i < 6; i++) step(1'b0, '0, 1'b1);
        checks++;
        if (occupancy !== CW'(0) || if_empty_n !== 1'b0 || if_full_n !== 1'b1 || overflow !== 1'b1) begin
            failures++;
            $display("FAIL grace_drain: occ=%0d empty_n=%b full_n=%b ovf=%b expected 0 0 1 1",
                     occupancy, if_empty_n, if_full_n, overflow);
        end
    endtask

    task automatic test_streaming();
        n_reads = 0;
        for (int i = 0; i < 20; i++) begin
            step(1'b1, DW'(i), 1'b1);
            checks++;
            if (occupancy !== CW'(1)) begin
                failures++;
                $display("FAIL stream_occ[%0d]: got %0d expected 1", i, occupancy);
            end
        end
        step(1'b0, '0, 1'b1);
        checks++;
        if (n_reads != 20 || occupancy !== CW'(0)) begin
            failures++;
            $display("FAIL stream_count: reads=%0d occ=%0d expected 20 0", n_reads, occupancy);
        end
    endtask

    task automatic test_empty_rw();
        step(1'b1, 8'h5A, 1'b1);
        checks++;
        if (occupancy !== CW'(1) || if_empty_n !== 1'b1 || if_dout !== 8'h5A) begin
            failures++;
            $display("FAIL empty_rw: occ=%0d empty_n=%b dout=%h expected 1 1 5a",
                     occupancy, if_empty_n, if_dout);
        end
        step(1'b0, '0, 1'b1);
        checks++;
        if (occupancy !== CW'(0) || if_empty_n !== 1'b0) begin
            failures++;
            $display("FAIL empty_rw_drain: occ=%0d empty_n=%b expected 0 0", occupancy, if_empty_n);
        end
    endtask

    task automatic test_full_read();
        apply_reset();
        checks++;
        if (overflow !== 1'b0) begin
            failures++;
            $display("FAIL full_read_ovf_clear: got %b expected 0", overflow);
        end
        for (int i = 1; i <= 6; i++) step(1'b1, DW'(i), 1'b0);
        step(1'b1, 8'hAA, 1'b1);
        checks++;
        if (occupancy !== CW'(6) || overflow !== 1'b0 || if_full_n !== 1'b0) begin
            failures++;
            $display("FAIL full_read: occ=%0d ovf=%b full_n=%b expected 6 0 0",
                     occupancy, overflow, if_full_n);
        end
        for (int i = 0; i < 5; i++) step(1'b0, '0, 1'b1);
        checks++;
        if (if_dout !== 8'hAA || occupancy !== CW'(1)) begin
            failures++;
            $display("FAIL full_read_last: dout=%h occ=%0d expected aa 1", if_dout, occupancy);
        end
        step(1'b0, '0, 1'b1);
    endtask

    task automatic test_reset_midstream();
        for (int i = 0; i < 3; i++) step(1'b1, DW'(8'h31 + i), 1'b0);
        reset    = 1'b1;
        if_write = 1'b1;
        if_din   = 8'hEE;
        if_read  = 1'b1;
        @(posedge clk);
        #1;
        m_occ = 0;
        sb.delete();
        checks++;
        if (occupancy !== CW'(0) || if_empty_n !== 1'b0 || if_full_n !== 1'b0) begin
            failures++;
            $display("FAIL mid_reset: occ=%0d empty_n=%b full_n=%b expected 0 0 0",
                     occupancy, if_empty_n, if_full_n);
        end
        reset    = 1'b0;
        if_write = 1'b0;
        if_read  = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if (if_full_n !== 1'b1 || if_empty_n !== 1'b0 || occupancy !== CW'(0)) begin
            failures++;
            $display("FAIL mid_reset_release: full_n=%b empty_n=%b occ=%0d expected 1 0 0",
                     if_full_n, if_empty_n, occupancy);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_fill();
        test_grace();
        test_streaming();
        test_empty_rw();
        test_full_read();
        test_reset_midstream();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_rs_hs_pipeline_tail_fifo
